// File: rtl/sample_uart_tx_pkg.sv
// Shared definitions for the sample UART transmitter: FSM states, frame
// constants and the sample-to-frame packing helper.
package sample_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    localparam logic [3:0] HDR_DEFAULT = 4'hA;
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;
    localparam int BIT_CNT_W  = $clog2(DATA_BITS);

    // Two-byte frame word: header nibble, then the 12-bit zero-extended sample.
    function automatic logic [15:0] build_frame(input logic [11:0] sample,
                                                input logic [3:0]  hdr);
        return {hdr, sample};
    endfunction

endpackage

// File: rtl/sample_uart_tx_if.sv
// Sample strobe bundle from the ADC driver into the UART transmitter.
interface sample_uart_tx_if #(
    parameter int DATA_W = 12
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;

    modport master (output sample_valid, output sample_data);
    modport slave  (input  sample_valid, input  sample_data);
endinterface

// File: rtl/sample_uart_tx_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the caller guarantees push is
// never issued when full without a same-cycle pop, and pop never when empty.
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 2**AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign level = count;
    assign full  = (count == DEPTH[AW:0]);
    assign empty = (count == '0);

endmodule

// File: rtl/sample_uart_tx.sv
// Buffers ADC samples and sends each one as a two-byte 8N1 frame
// (header nibble + sample) on the shared baud tick grid.
module sample_uart_tx
    import sample_uart_tx_pkg::*;
#(
    parameter int         DATA_W  = 12,
    parameter int         FIFO_AW = 3,
    parameter logic [3:0] HDR     = HDR_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             baud_tick,
    sample_uart_tx_if.slave  smp,
    output logic             tx,
    output logic             busy,
    output logic [FIFO_AW:0] fifo_level,
    output logic             overflow
);
    tx_state_e              state_q, state_n;
    logic                   tx_q, tx_n;
    logic [15:0]            frame_q, frame_n;
    logic                   byte_sel_q, byte_sel_n;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_n;
    logic [BIT_CNT_W-1:0]   bit_cnt_inc;
    logic                   overflow_q;
    logic                   push, pop, full, empty;
    logic [DATA_W-1:0]      head;
    logic [7:0]             cur_byte;

    // A full FIFO still accepts a sample when the FSM frees a slot that cycle.
    assign push = smp.sample_valid && (!full || pop);

    sync_fifo #(
        .WIDTH (DATA_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (smp.sample_data),
        .dout  (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    assign cur_byte    = byte_sel_q ? frame_q[7:0] : frame_q[15:8];
    assign bit_cnt_inc = bit_cnt_q + BIT_CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tx_q       <= 1'b1;
            frame_q    <= '0;
            byte_sel_q <= 1'b0;
            bit_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            tx_q       <= tx_n;
            frame_q    <= frame_n;
            byte_sel_q <= byte_sel_n;
            bit_cnt_q  <= bit_cnt_n;
            overflow_q <= overflow_q | (smp.sample_valid & ~push);
        end
    end

    always_comb begin
        state_n    = state_q;
        tx_n       = tx_q;
        frame_n    = frame_q;
        byte_sel_n = byte_sel_q;
        bit_cnt_n  = bit_cnt_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && !empty) begin
                    pop        = 1'b1;
                    frame_n    = build_frame(12'(head), HDR);
                    byte_sel_n = 1'b0;
                    state_n    = ST_ARM;
                end
            end
            ST_ARM: begin
                if (baud_tick) begin
                    tx_n    = 1'b0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    tx_n      = cur_byte[0];
                    bit_cnt_n = '0;
                    state_n   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                        tx_n    = 1'b1;
                        state_n = ST_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt_inc;
                        tx_n      = cur_byte[bit_cnt_inc];
                    end
                end
            end
            ST_STOP: begin
                // Byte 1 follows byte 0 with no idle gap between the two.
                if (baud_tick) begin
                    if (!byte_sel_q) begin
                        byte_sel_n = 1'b1;
                        tx_n       = 1'b0;
                        state_n    = ST_START;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_sample_uart_tx.sv
// Scoreboard bench for sample_uart_tx: accepted samples queue expected frames,
// a line monitor decodes tx and compares each frame against the queue.
module tb_sample_uart_tx;
    import sample_uart_tx_pkg::*;

    localparam int DATA_W    = 12;
    localparam int FIFO_AW   = 3;
    localparam int DEPTH     = 2**FIFO_AW;
    localparam int BAUD_DIV  = 16;
    localparam int FRAME_LEN = 2 * FRAME_BITS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             baud_tick = 1'b0;
    logic             tx;
    logic             busy;
    logic [FIFO_AW:0] fifo_level;
    logic             overflow;

    sample_uart_tx_if #(.DATA_W(DATA_W)) smp ();

    sample_uart_tx #(
        .DATA_W  (DATA_W),
        .FIFO_AW (FIFO_AW),
        .HDR     (HDR_DEFAULT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .baud_tick  (baud_tick),
        .smp        (smp),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    int          frames_seen = 0;
    logic        mon_active = 1'b0;
    logic [15:0] exp_q[$];
    logic        exp_overflow = 1'b0;

    always #5 clk = ~clk;

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            baud_tick = (cnt == BAUD_DIV - 1);
            cnt = (cnt == BAUD_DIV - 1) ? 0 : cnt + 1;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    endtask

    // Reference frame: byte0 = header nibble then sample bits above 8, byte1 = low 8 bits.
    function automatic logic [15:0] model_word(input logic [DATA_W-1:0] d);
        int s, byte0, byte1;
        s     = int'(d);
        byte0 = int'(HDR_DEFAULT) * 16 + (s / 256);
        byte1 = s % 256;
        return 16'(byte0 * 256 + byte1);
    endfunction

    function automatic logic [FRAME_LEN-1:0] expected_bits(input logic [15:0] w);
        logic [FRAME_LEN-1:0] v;
        logic [7:0]           by;
        v = '0;
        for (int k = 0; k < 2; k++) begin
            by = (k == 0) ? w[15:8] : w[7:0];
            v[k*FRAME_BITS] = 1'b0;
            for (int i = 0; i < 8; i++) v[k*FRAME_BITS + 1 + i] = by[i];
            v[k*FRAME_BITS + 9] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] rand_sample();
        return DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
    endfunction

    task automatic applyStimulus(input logic [DATA_W-1:0] d, input bit pop_now);
        smp.sample_data  = d;
        smp.sample_valid = 1'b1;
        if (exp_q.size() < DEPTH || pop_now) exp_q.push_back(model_word(d));
        else exp_overflow = 1'b1;
        @(negedge clk);
        smp.sample_valid = 1'b0;
    endtask

    task automatic doReset();
        #2 rst = 1'b0;
        exp_q.delete();
        exp_overflow = 1'b0;
        #1;
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !mon_active && busy === 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_drain"}, 32'(n < budget), 32'd1);
    endtask

    task automatic waitStart(input string name, input int budget);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_start"}, 32'(n < budget), 32'd1);
    endtask

    // Line monitor: samples every clock of all 20 bit periods of a frame.
    initial begin
        logic [FRAME_LEN-1:0] want, got;
        logic [15:0]          w;
        logic                 first_val, stable, busy_ok, have_exp, aborted;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx === 1'b0) begin
                mon_active = 1'b1;
                frames_seen++;
                have_exp = (exp_q.size() > 0);
                checkOutput("frame_expected", 32'(have_exp), 32'd1);
                w = have_exp ? exp_q.pop_front() : 16'h0;
                want = expected_bits(w);
                got = '0;
                stable = 1'b1;
                busy_ok = 1'b1;
                aborted = 1'b0;
                first_val = 1'b0;
                for (int b = 0; b < FRAME_LEN && !aborted; b++) begin
                    for (int s = 0; s < BAUD_DIV; s++) begin
                        if (b != 0 || s != 0) @(negedge clk);
                        if (rst !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (s == 0) first_val = tx;
                        else if (tx !== first_val) stable = 1'b0;
                        if (s == BAUD_DIV / 2) got[b] = tx;
                        if (busy !== 1'b1) busy_ok = 1'b0;
                    end
                end
                if (!aborted && have_exp) begin
                    checkOutput("frame_bits", 32'(got), 32'(want));
                    checkOutput("bit_timing", 32'(stable), 32'd1);
                    checkOutput("busy_in_frame", 32'(busy_ok), 32'd1);
                    @(negedge clk);
                    checkOutput("busy_after_frame", 32'(busy), 32'd0);
                    checkOutput("tx_after_frame", 32'(tx), 32'd1);
                end
                mon_active = 1'b0;
            end
        end
    end

    initial begin
        int f0;
        smp.sample_valid = 1'b0;
        smp.sample_data  = '0;

        $display("[TB] reset and idle line");
        doReset();
        repeat (1000 * BAUD_DIV) @(negedge clk);
        checkOutput("idle_tx", 32'(tx), 32'd1);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_level", 32'(fifo_level), 32'd0);
        checkOutput("idle_frames", 32'(frames_seen), 32'd0);

        $display("[TB] single sample");
        en = 1'b1;
        applyStimulus(12'h5C3, 1'b0);
        waitIdle("single", 40 * BAUD_DIV);
        checkOutput("single_frames", 32'(frames_seen), 32'd1);

        $display("[TB] overflow with en low");
        en = 1'b0;
        repeat (DEPTH + 1) applyStimulus(rand_sample(), 1'b0);
        checkOutput("ovf_level", 32'(fifo_level), 32'(exp_q.size()));
        checkOutput("ovf_flag", 32'(overflow), 32'(exp_overflow));
        f0 = frames_seen;
        en = 1'b1;
        waitIdle("ovf", DEPTH * 25 * BAUD_DIV);
        checkOutput("ovf_frames", 32'(frames_seen - f0), 32'(DEPTH));
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);

        $display("[TB] full FIFO with simultaneous push and pop");
        en = 1'b0;
        doReset();
        repeat (DEPTH) applyStimulus(rand_sample(), 1'b0);
        checkOutput("full_level", 32'(fifo_level), 32'(DEPTH));
        f0 = frames_seen;
        en = 1'b1;
        applyStimulus(rand_sample(), 1'b1);
        checkOutput("full_pp_level", 32'(fifo_level), 32'(DEPTH));
        checkOutput("full_pp_overflow", 32'(overflow), 32'(exp_overflow));
        waitIdle("full_pp", (DEPTH + 1) * 25 * BAUD_DIV);
        checkOutput("full_pp_frames", 32'(frames_seen - f0), 32'(DEPTH + 1));

        $display("[TB] random stream");
        f0 = frames_seen;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 30 * BAUD_DIV)) @(negedge clk);
            applyStimulus(rand_sample(), 1'b0);
        end
        waitIdle("stream", 8 * 25 * BAUD_DIV);
        checkOutput("stream_frames", 32'(frames_seen - f0), 32'd6);
        checkOutput("stream_overflow", 32'(overflow), 32'(exp_overflow));

        $display("[TB] en dropped mid-frame");
        en = 1'b0;
        repeat (3) applyStimulus(rand_sample(), 1'b0);
        f0 = frames_seen;
        en = 1'b1;
        waitStart("endrop", 4 * BAUD_DIV);
        repeat (4 * BAUD_DIV + BAUD_DIV / 2) @(negedge clk);
        en = 1'b0;
        repeat (60 * BAUD_DIV) @(negedge clk);
        checkOutput("endrop_frames", 32'(frames_seen - f0), 32'd1);
        checkOutput("endrop_level", 32'(fifo_level), 32'(exp_q.size()));
        checkOutput("endrop_tx", 32'(tx), 32'd1);
        checkOutput("endrop_busy", 32'(busy), 32'd0);

        $display("[TB] reset mid-frame");
        en = 1'b1;
        waitStart("midrst", 4 * BAUD_DIV);
        repeat (13 * BAUD_DIV) @(negedge clk);
        doReset();
        f0 = frames_seen;
        repeat (100 * BAUD_DIV) @(negedge clk);
        checkOutput("midrst_frames", 32'(frames_seen - f0), 32'd0);
        checkOutput("midrst_tx", 32'(tx), 32'd1);
        checkOutput("midrst_level", 32'(fifo_level), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
